// File: rtl/ram_bist_master.sv
// ram_bist_master: self-test master that writes a pattern over an address range,
// reads it back with a two-cycle read, and reports mismatches.
module ram_bist_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   fail_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_CMP, DONE} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d, last_q, last_d, addr_q, addr_d, fail_addr_q, fail_addr_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d, wdata_q, wdata_d, fail_data_q, fail_data_d;
  logic                we_q, we_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ADDR_W:0]     fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0]   addr_inc;
  logic                at_last;
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic [1:0] m,
                                                input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] lo;
    lo = DATA_W'(a);
    return m == 2'd0 ? s : m == 2'd1 ? (a[0] ? ~s : s) : m == 2'd2 ? lo ^ s : ~(lo ^ s);
  endfunction
  assign addr_inc = addr_q + ADDR_W'(1);
  assign at_last  = addr_q == last_q;
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    last_d      = last_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_cnt_d  = fail_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    case (state_q)
      IDLE: if (start) begin
        base_d     = base_addr;
        last_d     = last_addr;
        mode_d     = mode;
        seed_d     = seed;
        addr_d     = base_addr;
        wdata_d    = pattern(base_addr, mode, seed);
        we_d       = 1'b1;
        busy_d     = 1'b1;
        pass_d     = 1'b0;
        fail_cnt_d = '0;
        state_d    = WRITE;
      end
      WRITE: if (at_last) begin
        we_d    = 1'b0;
        addr_d  = base_q;
        state_d = RD_ADDR;
      end else begin
        addr_d  = addr_inc;
        wdata_d = pattern(addr_inc, mode_q, seed_q);
      end
      RD_ADDR: state_d = RD_CMP;
      RD_CMP: begin
        // Only the first mismatch is captured; later ones just count.
        if (ram_rdata != pattern(addr_q, mode_q, seed_q)) begin
          fail_cnt_d = fail_cnt_q + (ADDR_W+1)'(1);
          if (fail_cnt_q == '0) begin
            fail_addr_d = addr_q;
            fail_data_d = ram_rdata;
          end
        end
        if (at_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = fail_cnt_d == '0;
          state_d = DONE;
        end else begin
          addr_d  = addr_inc;
          state_d = RD_ADDR;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      last_q      <= '0;
      mode_q      <= '0;
      seed_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_cnt_q  <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
endmodule

// File: tb/tb_ram_bist_master.sv
// tb_ram_bist_master: directed runs against a registered-read RAM model with fault injection;
// expected writes are queued at launch and popped as the DUT writes.
module tb_ram_bist_master;
  logic        clk, rst_n, start, ram_we, busy, done, pass, fault;
  logic [9:0]  base_addr, last_addr, ram_addr, fail_addr, rb, span;
  logic [1:0]  mode;
  logic [7:0]  seed, ram_wdata, ram_rdata, fail_data, rd_q;
  logic [10:0] fail_cnt;
  logic [7:0]  mem [1024];
  logic [17:0] exp_q [$];
  int          total = 0, npass = 0, nfail = 0, dcnt = 0;

  ram_bist_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .last_addr(last_addr),
    .mode(mode), .seed(seed), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_q <= mem[ram_addr];
  end
  assign ram_rdata = rd_q ^ ((fault && (ram_addr == 10'd11 || ram_addr == 10'd13)) ? 8'h01 : 8'h00);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [9:0] a, input logic [1:0] m, input logic [7:0] s);
    case (m)
      2'd0: pat = s;
      2'd1: pat = a[0] ? ~s : s;
      2'd2: pat = a[7:0] ^ s;
      default: pat = ~(a[7:0] ^ s);
    endcase
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (ram_we) begin
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("write_addr", ram_addr, e[17:8]);
        check("write_data", ram_wdata, e[7:0]);
      end
    end
    if (busy) check("addr_in_range", 32'((ram_addr - rb) <= span), 1);
    if (done) dcnt++;
  end

  task automatic push_model(input logic [9:0] b, input int n, input logic [1:0] m, input logic [7:0] s);
    for (int i = 0; i < n; i++) exp_q.push_back({10'(b + 10'(i)), pat(10'(b + 10'(i)), m, s)});
  endtask

  task automatic launch(input logic [9:0] b, input logic [9:0] l, input logic [1:0] m, input logic [7:0] s);
    @(negedge clk);
    base_addr = b; last_addr = l; mode = m; seed = s; start = 1;
    rb = b; span = l - b; dcnt = 0;
    @(posedge clk);
    #1;
    start = 0;
    base_addr = 10'($urandom); last_addr = 10'($urandom); mode = 2'($urandom); seed = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_k, input bit poke);
    int k;
    k = 0;
    for (int i = 1; i <= exp_k + 20; i++) begin
      @(posedge clk);
      #1;
      if (poke && i == 3) begin start = 1; base_addr = 10'd100; last_addr = 10'd107; end
      if (poke && i == 4) start = 0;
      if (done) begin k = i; break; end
    end
    check("done_edge", k, exp_k);
    check("busy_at_done", busy, 0);
    if (poke) begin start = 1; base_addr = 10'd100; last_addr = 10'd107; end
    @(posedge clk);
    #1;
    start = 0;
    check("done_fall", done, 0);
    check("writes_all_seen", exp_q.size(), 0);
  endtask

  initial begin
    fault = 0; rst_n = 0; start = 1; base_addr = 10'd3; last_addr = 10'd9; mode = 2'd2; seed = 8'h3C;
    rb = 0; span = 0;
    repeat (3) @(negedge clk);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_data", fail_data, 0);
    start = 0; rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      check("idle_we", ram_we, 0);
      check("idle_busy", busy, 0);
    end
    // solid pattern
    for (int i = 0; i < 4; i++) exp_q.push_back({10'(10 + i), 8'hA5});
    launch(10'd10, 10'd13, 2'd0, 8'hA5);
    wait_done(12, 0);
    check("solid_pass", pass, 1);
    check("solid_cnt", fail_cnt, 0);
    // wrap-around
    exp_q.push_back({10'd1022, 8'hF1}); exp_q.push_back({10'd1023, 8'hF0});
    exp_q.push_back({10'd0, 8'h0F});    exp_q.push_back({10'd1, 8'h0E});
    launch(10'd1022, 10'd1, 2'd2, 8'h0F);
    wait_done(12, 0);
    check("wrap_pass", pass, 1);
    check("wrap_cnt", fail_cnt, 0);
    // injected fault
    fault = 1;
    exp_q.push_back({10'd10, 8'h55}); exp_q.push_back({10'd11, 8'hAA});
    exp_q.push_back({10'd12, 8'h55}); exp_q.push_back({10'd13, 8'hAA});
    launch(10'd10, 10'd13, 2'd1, 8'h55);
    wait_done(12, 0);
    check("fault_pass", pass, 0);
    check("fault_cnt", fail_cnt, 2);
    check("fault_addr", fail_addr, 11);
    check("fault_data", fail_data, 8'hAB);
    fault = 0;
    // start while busy and during DONE
    push_model(10'd0, 8, 2'd0, 8'h3C);
    launch(10'd0, 10'd7, 2'd0, 8'h3C);
    wait_done(24, 1);
    repeat (6) @(negedge clk);
    check("busy_done_count", dcnt, 1);
    check("busy_pass", pass, 1);
    check("busy_idle_busy", busy, 0);
    // single address
    exp_q.push_back({10'd7, 8'h7E});
    launch(10'd7, 10'd7, 2'd1, 8'h81);
    wait_done(3, 0);
    check("single_pass", pass, 1);
    // full RAM
    push_model(10'd5, 1024, 2'd3, 8'h3C);
    launch(10'd5, 10'd4, 2'd3, 8'h3C);
    wait_done(3072, 0);
    check("full_pass", pass, 1);
    check("full_cnt", fail_cnt, 0);
    // reset mid-run
    for (int i = 0; i < 4; i++) exp_q.push_back({10'(10 + i), 8'hA5});
    launch(10'd10, 10'd13, 2'd0, 8'hA5);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("midrst_we", ram_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_writes_seen", exp_q.size(), 3);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    push_model(10'd10, 4, 2'd2, 8'h77);
    launch(10'd10, 10'd13, 2'd2, 8'h77);
    wait_done(12, 0);
    check("after_rst_pass", pass, 1);
    check("after_rst_cnt", fail_cnt, 0);
    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
